// File: rtl/sqrt_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_lut_arbiter
// Brief    : Round-robin sharing of one sqrt LUT between two sample streams,
//            with negative clamping and tag-based result routing.
// Revision : 1.0
// ============================================================================
module sqrt_lut_arbiter #(
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic          ch0_valid_i,
    output logic          ch0_ready_o,
    input  logic [DW-1:0] ch1_data_i,
    input  logic          ch1_valid_i,
    output logic          ch1_ready_o,
    output logic [DW-1:0] lut_data_o,
    input  logic [DW-1:0] lut_data_i,
    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    output logic          ch0_neg_o,
    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    output logic          ch1_neg_o,
    input  logic          clr_i
);

    logic          r_last;      // 1: most recent grant went to ch1
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_issue;
    logic          w_neg;
    logic [DW-1:0] w_sel;
    // Stage 0 is aligned with lut_data_o; stage LAT is aligned with lut_data_i.
    logic [LAT:0]  r_tag_vld;
    logic [LAT:0]  r_tag_ch;

    assign w_gnt0      = rstn_i & ch0_valid_i & (~ch1_valid_i | r_last);
    assign w_gnt1      = rstn_i & ch1_valid_i & (~ch0_valid_i | ~r_last);
    assign ch0_ready_o = w_gnt0;
    assign ch1_ready_o = w_gnt1;
    assign w_issue     = w_gnt0 | w_gnt1;
    assign w_sel       = w_gnt1 ? ch1_data_i : ch0_data_i;
    assign w_neg       = w_issue & w_sel[DW-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_last     <= 1'b1;
            lut_data_o <= '0;
            r_tag_vld  <= '0;
            r_tag_ch   <= '0;
        end else begin
            if (w_issue) begin
                r_last <= w_gnt1;
            end
            lut_data_o <= (w_issue && !w_neg) ? w_sel : '0;
            r_tag_vld  <= {r_tag_vld[LAT-1:0], w_issue};
            r_tag_ch   <= {r_tag_ch[LAT-1:0], w_gnt1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ch0_data_o  <= '0;
            ch1_data_o  <= '0;
            ch0_valid_o <= 1'b0;
            ch1_valid_o <= 1'b0;
            ch0_neg_o   <= 1'b0;
            ch1_neg_o   <= 1'b0;
        end else begin
            ch0_valid_o <= r_tag_vld[LAT] & ~r_tag_ch[LAT];
            ch1_valid_o <= r_tag_vld[LAT] & r_tag_ch[LAT];
            if (r_tag_vld[LAT] && !r_tag_ch[LAT]) begin
                ch0_data_o <= lut_data_i;
            end
            if (r_tag_vld[LAT] && r_tag_ch[LAT]) begin
                ch1_data_o <= lut_data_i;
            end
            // A new negative sample outranks a simultaneous clear.
            ch0_neg_o <= (w_gnt0 & w_neg) | (ch0_neg_o & ~clr_i);
            ch1_neg_o <= (w_gnt1 & w_neg) | (ch1_neg_o & ~clr_i);
        end
    end

endmodule
`default_nettype wire
